// File: rtl/systick_alarm.sv
// systick_alarm: Wishbone-slave compare/alarm unit fed by systick's tick_count.
// Raises a level interrupt when the tick counter reaches a programmed compare value.
// Supports one-shot and periodic auto-reload modes, with pending/overrun status.
module systick_alarm #(
    parameter logic [31:0] BaseAddr = 32'h4040
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] tick_count_in,
    input  logic        wb_we,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_addr,
    output logic        wb_err,
    output logic        wb_ack,
    output logic [31:0] wb_rdata,
    output logic        irq_out
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_CMP    = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Registered state
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        en_q, en_d;
    logic        irqen_q, irqen_d;
    logic        periodic_q, periodic_d;
    logic [31:0] cmp_q, cmp_d;
    logic [31:0] period_q, period_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic [31:0] tick_prev_q, tick_prev_d;

    // Bus decode
    logic [31:0] offset;
    logic        off_valid;
    logic [1:0]  reg_idx;
    logic        req;
    logic        wr_ok;
    logic        wr_ctrl;
    logic        wr_cmp;
    logic        wr_period;
    logic        wr_status;
    logic [31:0] read_val;

    // Tick / match
    logic        new_tick;
    logic        match;

    // Merge selected byte lanes of the write data onto the current register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign offset    = wb_addr - BaseAddr;
    assign off_valid = (offset[31:4] == 28'd0) && (offset[1:0] == 2'b00);
    assign reg_idx   = offset[3:2];

    // A new request is blocked while its own response is on the bus, so a
    // held strobe produces one response every second cycle.
    assign req       = wb_cyc & wb_stb & ~(ack_q | err_q);
    assign wr_ok     = req & off_valid & wb_we;
    assign wr_ctrl   = wr_ok & (reg_idx == REG_CTRL);
    assign wr_cmp    = wr_ok & (reg_idx == REG_CMP);
    assign wr_period = wr_ok & (reg_idx == REG_PERIOD);
    assign wr_status = wr_ok & (reg_idx == REG_STATUS);

    assign new_tick  = (tick_count_in != tick_prev_q);
    // Compare is always against the pre-write CMP value.
    assign match     = new_tick & en_q & (tick_count_in == cmp_q);

    // Read multiplexer over the register window (unused bits read as zero).
    always_comb begin
        read_val = 32'd0;
        case (reg_idx)
            REG_CTRL:   read_val = {29'd0, periodic_q, irqen_q, en_q};
            REG_CMP:    read_val = cmp_q;
            REG_PERIOD: read_val = period_q;
            REG_STATUS: read_val = {30'd0, ovr_q, pend_q};
            default:    read_val = 32'd0;
        endcase
    end

    // Next-state logic: bus response, register writes, alarm match and reload.
    always_comb begin
        ack_d       = req & off_valid;
        err_d       = req & ~off_valid;
        rdata_d     = (req & off_valid) ? read_val : 32'd0;
        tick_prev_d = tick_count_in;

        en_d        = en_q;
        irqen_d     = irqen_q;
        periodic_d  = periodic_q;
        cmp_d       = cmp_q;
        period_d    = period_q;
        pend_d      = pend_q;
        ovr_d       = ovr_q;

        // Status write-1-to-clear goes first so a same-cycle match can re-set it.
        if (wr_status && wb_sel[0]) begin
            if (wb_wdata[0]) begin
                pend_d = 1'b0;
            end
            if (wb_wdata[1]) begin
                ovr_d = 1'b0;
            end
        end

        // Alarm match: first hit sets PEND, hits while PEND is still set flag OVR.
        if (match) begin
            pend_d = 1'b1;
            if (pend_q) begin
                ovr_d = 1'b1;
            end
            if (periodic_q) begin
                cmp_d = cmp_q + period_q;
            end else begin
                en_d = 1'b0;
            end
        end

        // Bus writes to CTRL/CMP/PERIOD take precedence over the match side effects.
        if (wr_ctrl && wb_sel[0]) begin
            en_d       = wb_wdata[0];
            irqen_d    = wb_wdata[1];
            periodic_d = wb_wdata[2];
        end
        if (wr_cmp) begin
            cmp_d = merge_bytes(cmp_q, wb_wdata, wb_sel);
        end
        if (wr_period) begin
            period_d = merge_bytes(period_q, wb_wdata, wb_sel);
        end
    end

    // State registers; reset clears everything and drops any in-flight response.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            en_q        <= 1'b0;
            irqen_q     <= 1'b0;
            periodic_q  <= 1'b0;
            cmp_q       <= 32'd0;
            period_q    <= 32'd0;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            tick_prev_q <= 32'd0;
        end else begin
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            en_q        <= en_d;
            irqen_q     <= irqen_d;
            periodic_q  <= periodic_d;
            cmp_q       <= cmp_d;
            period_q    <= period_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            tick_prev_q <= tick_prev_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_err   = err_q;
    assign wb_rdata = rdata_q;
    assign irq_out  = pend_q & irqen_q;

endmodule

// File: tb/tb_systick_alarm.sv
// tb_systick_alarm: table-driven register checks, hand-written corner sequences,
// and a randomized phase checked against an event-level model of the alarm.
module tb_systick_alarm;

    localparam logic [31:0] A_CTRL   = 32'h4040;
    localparam logic [31:0] A_CMP    = 32'h4044;
    localparam logic [31:0] A_PERIOD = 32'h4048;
    localparam logic [31:0] A_STATUS = 32'h404C;

    logic        clk_in;
    logic        reset_in;
    logic [31:0] tick_count_in;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic [3:0]  wb_sel;
    logic [31:0] wb_wdata;
    logic [31:0] wb_addr;
    logic        wb_err;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        irq_out;

    int vectors = 0;
    int miscompares = 0;

    systick_alarm #(.BaseAddr(32'h4040)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .tick_count_in (tick_count_in),
        .wb_we         (wb_we),
        .wb_stb        (wb_stb),
        .wb_cyc        (wb_cyc),
        .wb_sel        (wb_sel),
        .wb_wdata      (wb_wdata),
        .wb_addr       (wb_addr),
        .wb_err        (wb_err),
        .wb_ack        (wb_ack),
        .wb_rdata      (wb_rdata),
        .irq_out       (irq_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // ---------------- reference model (event level) ----------------
    logic        m_en, m_irqen, m_per, m_pend, m_ovr;
    logic [31:0] m_cmp, m_period;

    task automatic model_reset();
        m_en = 0; m_irqen = 0; m_per = 0; m_pend = 0; m_ovr = 0;
        m_cmp = 0; m_period = 0;
    endtask

    // Called whenever the tick counter takes a new value.
    task automatic model_tick(input logic [31:0] t);
        if (m_en && t == m_cmp) begin
            if (m_pend) m_ovr = 1;
            m_pend = 1;
            if (m_per) m_cmp = m_cmp + m_period;
            else       m_en = 0;
        end
    endtask

    task automatic model_write(input int idx, input logic [3:0] sel, input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                case (idx)
                    1: m_cmp[8*b +: 8]    = d[8*b +: 8];
                    2: m_period[8*b +: 8] = d[8*b +: 8];
                    default: ;
                endcase
            end
        end
        if (idx == 0 && sel[0]) begin
            m_en = d[0]; m_irqen = d[1]; m_per = d[2];
        end
        if (idx == 3 && sel[0]) begin
            if (d[0]) m_pend = 0;
            if (d[1]) m_ovr = 0;
        end
    endtask

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return {29'd0, m_per, m_irqen, m_en};
            1: return m_cmp;
            2: return m_period;
            default: return {30'd0, m_ovr, m_pend};
        endcase
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus transaction, followed by one idle cycle; also checks the response is a single pulse.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] data, output logic ack, output logic err,
                       output logic [31:0] rd);
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_addr = addr; wb_sel = sel; wb_wdata = data;
        @(posedge clk_in); #1;
        ack = wb_ack; err = wb_err; rd = wb_rdata;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(posedge clk_in); #1;
        chk("resp_single_pulse", {30'd0, wb_ack, wb_err}, 32'd0);
    endtask

    task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel = 4'hF);
        logic a, e; logic [31:0] r;
        bus(1'b1, addr, sel, data, a, e, r);
        chk({name, "_ack"}, {31'd0, a}, 32'd1);
        chk({name, "_err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic a, e; logic [31:0] r;
        bus(1'b0, addr, 4'hF, 32'd0, a, e, r);
        chk({name, "_ack"}, {31'd0, a}, 32'd1);
        chk({name, "_err"}, {31'd0, e}, 32'd0);
        chk({name, "_rdata"}, r, exp);
    endtask

    task automatic step(input logic [31:0] t);
        tick_count_in = t;
        @(posedge clk_in); #1;
    endtask

    task automatic do_reset();
        reset_in = 0;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(posedge clk_in); @(posedge clk_in); #1;
        reset_in = 1;
        @(posedge clk_in); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        chk_rd;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic a, e;
        logic [31:0] r;
        logic [31:0] t;
        logic [3:0]  sel;
        logic [31:0] addr, data;
        int          idx, op;
        logic        bad;

        tbl[0]  = '{1'b0, A_CTRL,         4'hF, 32'h0,        1, 0, 32'h0,        1};
        tbl[1]  = '{1'b0, A_CMP,          4'hF, 32'h0,        1, 0, 32'h0,        1};
        tbl[2]  = '{1'b0, A_PERIOD,       4'hF, 32'h0,        1, 0, 32'h0,        1};
        tbl[3]  = '{1'b0, A_STATUS,       4'hF, 32'h0,        1, 0, 32'h0,        1};
        tbl[4]  = '{1'b0, A_CTRL + 32'h10, 4'hF, 32'h0,       0, 1, 32'h0,        1};
        tbl[5]  = '{1'b0, A_CTRL + 32'h2, 4'hF, 32'h0,        0, 1, 32'h0,        1};
        tbl[6]  = '{1'b1, A_CMP,          4'b0010, 32'hAABBCCDD, 1, 0, 32'h0,     0};
        tbl[7]  = '{1'b0, A_CMP,          4'hF, 32'h0,        1, 0, 32'h0000CC00, 1};
        tbl[8]  = '{1'b1, A_CTRL + 32'h10, 4'hF, 32'h12345678, 0, 1, 32'h0,       1};
        tbl[9]  = '{1'b0, A_CMP,          4'hF, 32'h0,        1, 0, 32'h0000CC00, 1};
        tbl[10] = '{1'b1, A_CTRL,         4'hF, 32'hFFFFFFF8, 1, 0, 32'h0,        0};
        tbl[11] = '{1'b0, A_CTRL,         4'hF, 32'h0,        1, 0, 32'h0,        1};
        tbl[12] = '{1'b1, A_PERIOD,       4'b1100, 32'h12345678, 1, 0, 32'h0,     0};
        tbl[13] = '{1'b0, A_PERIOD,       4'hF, 32'h0,        1, 0, 32'h12340000, 1};
        tbl[14] = '{1'b1, A_CTRL,         4'b0001, 32'h6,     1, 0, 32'h0,        0};
        tbl[15] = '{1'b0, A_CTRL,         4'hF, 32'h0,        1, 0, 32'h6,        1};
        tbl[16] = '{1'b1, A_STATUS,       4'hF, 32'hFFFFFFFF, 1, 0, 32'h0,        0};
        tbl[17] = '{1'b0, A_STATUS,       4'hF, 32'h0,        1, 0, 32'h0,        1};

        reset_in = 0; tick_count_in = 0;
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_wdata = 0; wb_addr = 0;
        #1;
        chk("reset_ack", {31'd0, wb_ack}, 32'd0);
        chk("reset_err", {31'd0, wb_err}, 32'd0);
        chk("reset_irq", {31'd0, irq_out}, 32'd0);
        do_reset();
        chk("post_reset_irq", {31'd0, irq_out}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            bus(tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].data, a, e, r);
            chk($sformatf("tbl%0d_ack", i), {31'd0, a}, {31'd0, tbl[i].exp_ack});
            chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
            if (tbl[i].chk_rd)
                chk($sformatf("tbl%0d_rdata", i), r, tbl[i].exp_rd);
        end

        // One-shot alarm at tick 5
        do_reset();
        tick_count_in = 0;
        wr("os_cmp", A_CMP, 32'd5);
        wr("os_ctrl", A_CTRL, 32'h3);
        for (int k = 1; k <= 6; k++) begin
            step(k);
            chk($sformatf("os_irq_t%0d", k), {31'd0, irq_out}, (k >= 5) ? 32'd1 : 32'd0);
        end
        rd("os_ctrl_rb", A_CTRL, 32'h2);
        rd("os_stat_rb", A_STATUS, 32'h1);
        wr("os_w1c", A_STATUS, 32'h1);
        chk("os_irq_cleared", {31'd0, irq_out}, 32'd0);

        // Periodic: matches at 10,14,18,22
        do_reset();
        wr("per_cmp", A_CMP, 32'd10);
        wr("per_period", A_PERIOD, 32'd4);
        wr("per_ctrl", A_CTRL, 32'h7);
        for (int k = 7; k <= 22; k++) begin
            step(k);
            chk($sformatf("per_irq_t%0d", k), {31'd0, irq_out}, (k >= 10) ? 32'd1 : 32'd0);
            if (k == 10) rd("per_stat_first", A_STATUS, 32'h1);
        end
        rd("per_stat_end", A_STATUS, 32'h3);
        rd("per_cmp_end", A_CMP, 32'd26);
        rd("per_ctrl_end", A_CTRL, 32'h7);

        // Periodic reload across the 32-bit wrap
        do_reset();
        step(32'hFFFFFFFC);
        wr("wrap_cmp", A_CMP, 32'hFFFFFFFE);
        wr("wrap_period", A_PERIOD, 32'd3);
        wr("wrap_ctrl", A_CTRL, 32'h7);
        step(32'hFFFFFFFD);
        chk("wrap_irq_fd", {31'd0, irq_out}, 32'd0);
        step(32'hFFFFFFFE);
        chk("wrap_irq_fe", {31'd0, irq_out}, 32'd1);
        rd("wrap_cmp1", A_CMP, 32'h1);
        rd("wrap_stat1", A_STATUS, 32'h1);
        wr("wrap_w1c", A_STATUS, 32'h3);
        step(32'hFFFFFFFF);
        step(32'h0);
        chk("wrap_irq_0", {31'd0, irq_out}, 32'd0);
        step(32'h1);
        chk("wrap_irq_1", {31'd0, irq_out}, 32'd1);
        rd("wrap_stat2", A_STATUS, 32'h1);
        rd("wrap_cmp2", A_CMP, 32'h4);

        // Match and W1C on the same cycle: set wins
        do_reset();
        wr("sim_cmp", A_CMP, 32'd3);
        wr("sim_ctrl", A_CTRL, 32'h3);
        step(32'd2);
        tick_count_in = 32'd3;
        wr("sim_w1c", A_STATUS, 32'h3);
        rd("sim_stat", A_STATUS, 32'h1);
        chk("sim_irq", {31'd0, irq_out}, 32'd1);

        // CMP write vs periodic reload on the same cycle: bus value wins
        do_reset();
        wr("rl_cmp", A_CMP, 32'd5);
        wr("rl_period", A_PERIOD, 32'd5);
        wr("rl_ctrl", A_CTRL, 32'h5);
        step(32'd4);
        tick_count_in = 32'd5;
        wr("rl_cmp_wr", A_CMP, 32'h100);
        rd("rl_cmp_rb", A_CMP, 32'h100);
        rd("rl_stat_rb", A_STATUS, 32'h1);

        // CTRL write vs one-shot EN clear on the same cycle: bus value wins
        do_reset();
        wr("oc_cmp", A_CMP, 32'd7);
        wr("oc_ctrl", A_CTRL, 32'h1);
        step(32'd6);
        tick_count_in = 32'd7;
        wr("oc_ctrl_wr", A_CTRL, 32'h3);
        rd("oc_ctrl_rb", A_CTRL, 32'h3);
        rd("oc_stat_rb", A_STATUS, 32'h1);

        // Enabling while the tick already equals CMP must not fire
        do_reset();
        step(32'd10);
        wr("eq_cmp", A_CMP, 32'd10);
        wr("eq_ctrl", A_CTRL, 32'h3);
        repeat (3) @(posedge clk_in);
        #1;
        rd("eq_stat", A_STATUS, 32'h0);
        step(32'd11);
        chk("eq_irq", {31'd0, irq_out}, 32'd0);

        // Held strobe: response every second cycle
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = A_CTRL; wb_sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in); #1;
            chk($sformatf("held_ack%0d", k), {31'd0, wb_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        wb_cyc = 0; wb_stb = 0;
        @(posedge clk_in); #1;

        // Reset in the middle of a write
        wr("mr_cmp", A_CMP, 32'd12);
        step(32'd12);
        chk("mr_irq_pre", {31'd0, irq_out}, 32'd1);
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = A_CMP; wb_sel = 4'hF; wb_wdata = 32'h55;
        #2 reset_in = 0;
        #1;
        chk("mr_irq_async", {31'd0, irq_out}, 32'd0);
        chk("mr_ack_async", {31'd0, wb_ack}, 32'd0);
        @(posedge clk_in); #1;
        chk("mr_ack_edge", {31'd0, wb_ack}, 32'd0);
        chk("mr_err_edge", {31'd0, wb_err}, 32'd0);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        reset_in = 1;
        @(posedge clk_in); #1;
        rd("mr_cmp_rb", A_CMP, 32'h0);
        rd("mr_ctrl_rb", A_CTRL, 32'h0);
        rd("mr_stat_rb", A_STATUS, 32'h0);

        // Randomized phase against the model, crossing the counter wrap
        do_reset();
        model_reset();
        t = 32'hFFFFFF80;
        step(t);
        for (int it = 0; it < 600; it++) begin
            op = $urandom_range(0, 9);
            if (op < 5) begin
                t = t + 32'($urandom_range(1, 2));
                model_tick(t);
                step(t);
                chk("rnd_irq", {31'd0, irq_out}, {31'd0, m_pend & m_irqen});
            end else begin
                idx = $urandom_range(0, 3);
                bad = ($urandom_range(0, 7) == 0);
                if (bad)
                    addr = ($urandom_range(0, 1) == 1) ? A_CTRL + 32'h10 + 32'($urandom_range(0, 7) * 4)
                                                       : A_CTRL + 32'(idx * 4) + 32'($urandom_range(1, 3));
                else
                    addr = A_CTRL + 32'(idx * 4);
                if (op < 7) begin
                    sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
                    case (idx)
                        0: data = $urandom;
                        1: data = t + 32'($urandom_range(0, 8));
                        2: data = 32'($urandom_range(0, 5));
                        default: data = $urandom;
                    endcase
                    bus(1'b1, addr, sel, data, a, e, r);
                    if (!bad) model_write(idx, sel, data);
                    chk("rnd_wr_ack", {31'd0, a}, {31'd0, ~bad});
                    chk("rnd_wr_err", {31'd0, e}, {31'd0, bad});
                end else begin
                    bus(1'b0, addr, 4'hF, 32'd0, a, e, r);
                    chk("rnd_rd_ack", {31'd0, a}, {31'd0, ~bad});
                    chk("rnd_rd_err", {31'd0, e}, {31'd0, bad});
                    chk("rnd_rd_data", r, bad ? 32'd0 : model_read(idx));
                end
                chk("rnd_irq_bus", {31'd0, irq_out}, {31'd0, m_pend & m_irqen});
            end
        end
        for (int k = 0; k < 4; k++) begin
            bus(1'b0, A_CTRL + 32'(k * 4), 4'hF, 32'd0, a, e, r);
            chk($sformatf("rnd_final_reg%0d", k), r, model_read(k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
